seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Time-multiplexed driver for a common-anode multi-digit 7-segment display.
- Sits directly downstream of the per-digit hex-to-segment counter/decoder stages and consumes their active-low 7-bit segment patterns (bit order g..a, 7'b1000000 = "0").
- Scans one digit at a time, with a blanking gap between digits to suppress ghosting.
- Emits one shared segment bus plus active-low anode selects.

Parameters:
- DIGITS, 4: number of digits scanned; must be at least 2.
- DWELL, 50000: clk cycles each digit is lit; must be at least 1.
- BLANK, 16: clk cycles all digits are dark between digits; 0 disables blanking.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- seg_in  input  DIGITS*7  active-low segment patterns; digit k occupies bits [7k+6:7k].
- dp_in  input  DIGITS  active-low decimal points, one per digit.
- digit_en  input  DIGITS  1 = digit k may be lit; 0 = digit k stays dark in its slot.
- seg_out  output  7  active-low segment bus.
- dp_out  output  1  active-low decimal point.
- an_out  output  DIGITS  active-low anode selects; at most one bit is low.
- frame_done  output  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - state = BLANK, idx = 0, timer = 0.
  - seg_out = 7'h7F, dp_out = 1, an_out = all 1s, frame_done = 0.
  - Reset asserted mid-scan takes effect at the next edge, regardless of state.
- Outputs come from registers only (state, idx, seg_lat, dp_lat, en_lat). There is no combinational path from any input to any output.
- States:
  - BLANK: an_out all 1s, seg_out 7'h7F, dp_out 1. timer counts 0..BLANK-1. On the cycle timer = BLANK-1:
    - go to SHOW;
    - latch seg_lat <= seg_in[idx], dp_lat <= dp_in[idx], en_lat <= digit_en[idx];
    - clear timer.
  - SHOW: seg_out = seg_lat, dp_out = dp_lat, an_out[idx] = ~en_lat, all other an_out bits 1. timer counts 0..DWELL-1. On the cycle timer = DWELL-1:
    - idx <= idx+1, wrapping DIGITS-1 -> 0;
    - clear timer;
    - go to BLANK, or stay in SHOW and latch the next digit's inputs when BLANK = 0.
- Input sampling: inputs are sampled only at SHOW entry. Changes to seg_in, dp_in or digit_en during a dwell do not affect the lit digit until its next slot (no tearing).
- With en_lat = 0, an_out stays all 1s. seg_out/dp_out still carry the latched pattern, which is harmless because no anode is driven.
- frame_done: registered and high for exactly the one cycle following the SHOW->next transition in which idx wraps to 0.
- Timing:
  - Each slot is BLANK + DWELL cycles; a frame is DIGITS*(BLANK+DWELL) cycles.
  - The first lit cycle of digit 0 after reset is cycle BLANK, counting the first non-reset cycle as 0.
- Width rules:
  - timer width = clog2(max(DWELL, BLANK, 2)).
  - idx width = clog2(DIGITS).
  - idx compare/wrap is explicit, so non-power-of-2 DIGITS is legal.

Decomposition:
- Shared package seg_pkg:
  - state enum {ST_BLANK, ST_SHOW};
  - SEG_OFF = 7'h7F;
  - SEG_W = 7;
  - the hex segment constants (digit "0" = 7'b1000000, etc.), reused by decoder stages.
- Sub-module scan_timer: loadable cycle counter with clear and terminal-count output, instantiated once and reused for both BLANK and DWELL phases.
- Everything else lives in the top module.

Test Plan (DIGITS=4, DWELL=4, BLANK=2 unless noted):
- Basic scan:
  - Stimulus: reset 1 cycle, seg_in = {7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000} ("3210"), digit_en = 4'b1111.
  - Response: cycles 0-1 an_out = 4'b1111 and seg_out = 7'h7F; cycles 2-5 an_out = 4'b1110, seg_out = 7'b1000000; cycles 6-7 dark; cycles 8-11 an_out = 4'b1101, seg_out = 7'b1111001.
  - frame_done pulses once every 24 cycles, at the wrap into digit 0.
- Masking: digit_en = 4'b1011 -> in digit 2's slot an_out stays 4'b1111 for all 6 cycles; other digits scan as in the basic case.
- Stability: change seg_in digit 0 to 7'b0010000 in the 2nd cycle of digit 0's dwell -> seg_out holds 7'b1000000 to the end of that slot; 7'b0010000 appears in the next frame.
- Zero blanking: BLANK=0 -> an_out steps 1110 -> 1101 -> 1011 -> 0111 every 4 cycles with no dark cycles; frame = 16 cycles.
- Reset mid-dwell: assert reset during digit 2's SHOW -> next edge gives an_out = 4'b1111, seg_out = 7'h7F, frame_done = 0; after release, digit 0 is lit at cycle 2.
- One-hot check: random seg_in/digit_en over 1000 frames -> an_out never has more than one 0 bit; frame_done is never high for 2 consecutive cycles.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared types and constants for the 7-segment display path.
//                Segment patterns are active-low, bit order g..a.
//                Contents:
//                  SEG_W        - width of one segment pattern
//                  SEG_OFF      - all segments dark
//                  HEX_SEG      - hex digit 0..F to segment pattern table
//                  scan_state_t - scan FSM state encoding
//                  max3()       - helper for sizing counters
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    // Common-anode hex font, index 0 is the rightmost entry.
    localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
//  Module      : scan_timer
//  Description : Free-running up-counter with synchronous clear and a
//                terminal-count flag. The terminal value is supplied every
//                cycle so one instance serves both the blank and dwell phases.
//  Ports       : clk   - clock
//                rst   - synchronous active-high reset (count -> 0)
//                clear - restart counting from 0 on the next edge
//                limit - terminal value for the current phase
//                done  - high while count == limit
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign done = (r_count == limit);

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Time-multiplexed driver for a common-anode multi-digit
//                7-segment display. Each digit slot is a dark gap of BLANK
//                cycles followed by DWELL lit cycles. Digit inputs are latched
//                once at the start of the lit phase so the shown digit never
//                tears.
//  Ports       : clk        - clock
//                reset      - synchronous active-high reset
//                seg_in     - DIGITS x 7 active-low patterns, digit k at [7k+6:7k]
//                dp_in      - active-low decimal points, one per digit
//                digit_en   - per-digit enable (0 keeps the digit dark)
//                seg_out    - active-low shared segment bus
//                dp_out     - active-low shared decimal point
//                an_out     - active-low anode selects (at most one low)
//                frame_done - one-cycle pulse after the wrap back to digit 0
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DWELL  = 50000,
    parameter int BLANK  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DIGITS*SEG_W-1:0] seg_in,
    input  logic [DIGITS-1:0]       dp_in,
    input  logic [DIGITS-1:0]       digit_en,
    output logic [SEG_W-1:0]        seg_out,
    output logic                    dp_out,
    output logic [DIGITS-1:0]       an_out,
    output logic                    frame_done
);

    localparam int c_TIMER_W = $clog2(max3(DWELL, BLANK, 2));
    localparam int c_IDX_W   = $clog2(DIGITS);

    localparam logic [c_TIMER_W-1:0] c_DWELL_LAST = c_TIMER_W'(DWELL - 1);
    // With BLANK = 0 the blank phase only exists right after reset; a limit
    // of 0 makes it last a single cycle.
    localparam logic [c_TIMER_W-1:0] c_BLANK_LAST = c_TIMER_W'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [c_IDX_W-1:0]   c_IDX_LAST   = c_IDX_W'(DIGITS - 1);

    scan_state_t          r_state;
    scan_state_t          w_state_next;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   w_idx_next;
    logic [c_IDX_W-1:0]   w_sel_idx;
    logic [SEG_W-1:0]     r_seg_lat;
    logic                 r_dp_lat;
    logic                 r_en_lat;
    logic                 r_frame_done;
    logic                 w_tc;
    logic                 w_slot_end;
    logic                 w_wrap;
    logic                 w_load;
    logic [c_TIMER_W-1:0] w_limit;
    logic [DIGITS-1:0]    w_an;
    logic [SEG_W-1:0]     w_seg_arr [DIGITS];

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_unpack
            assign w_seg_arr[k] = seg_in[SEG_W*k +: SEG_W];
        end
    endgenerate

    scan_timer #(
        .WIDTH (c_TIMER_W)
    ) u_timer (
        .clk   (clk),
        .rst   (reset),
        .clear (w_tc),
        .limit (w_limit),
        .done  (w_tc)
    );

    // ------------------------------------------------------------------
    // Next-state and control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_slot_end   = 1'b0;
        w_wrap       = 1'b0;
        w_load       = 1'b0;
        w_limit      = c_BLANK_LAST;
        w_sel_idx    = r_idx;

        case (r_state)
            ST_BLANK: begin
                w_limit = c_BLANK_LAST;
                if (w_tc) begin
                    w_state_next = ST_SHOW;
                    w_load       = 1'b1;
                end
            end
            ST_SHOW: begin
                w_limit = c_DWELL_LAST;
                if (w_tc) begin
                    w_slot_end = 1'b1;
                    w_wrap     = (r_idx == c_IDX_LAST);
                    w_idx_next = w_wrap ? '0 : r_idx + 1'b1;
                    if (BLANK == 0) begin
                        // Back-to-back slots: latch the following digit now.
                        w_state_next = ST_SHOW;
                        w_load       = 1'b1;
                    end else begin
                        w_state_next = ST_BLANK;
                    end
                end
                w_sel_idx = w_idx_next;
            end
            default: begin
                w_state_next = ST_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_BLANK;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx        <= '0;
            r_seg_lat    <= SEG_OFF;
            r_dp_lat     <= 1'b1;
            r_en_lat     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_idx        <= w_idx_next;
            r_frame_done <= w_wrap;
            if (w_load) begin
                r_seg_lat <= w_seg_arr[w_sel_idx];
                r_dp_lat  <= dp_in[w_sel_idx];
                r_en_lat  <= digit_en[w_sel_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registers only
    // ------------------------------------------------------------------
    always_comb begin
        w_an = '1;
        if (r_state == ST_SHOW && r_en_lat) begin
            w_an[r_idx] = 1'b0;
        end
    end

    assign an_out     = w_an;
    assign seg_out    = (r_state == ST_SHOW) ? r_seg_lat : SEG_OFF;
    assign dp_out     = (r_state == ST_SHOW) ? r_dp_lat : 1'b1;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_driver
//  Description : Directed bench for seg_scan_driver. Instance u_a uses
//                DIGITS=4, DWELL=4, BLANK=2; instance u_b uses BLANK=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset_a;
    logic        reset_b;
    logic [27:0] seg_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  an_a, an_b;
    logic        fd_a, fd_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] pat [4] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000};

    always #5 clk = ~clk;

    seg_scan_driver #(.DIGITS(4), .DWELL(4), .BLANK(2)) u_a (
        .clk        (clk),
        .reset      (reset_a),
        .seg_in     (seg_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .seg_out    (seg_a),
        .dp_out     (dp_a),
        .an_out     (an_a),
        .frame_done (fd_a)
    );

    seg_scan_driver #(.DIGITS(4), .DWELL(4), .BLANK(0)) u_b (
        .clk        (clk),
        .reset      (reset_b),
        .seg_in     (seg_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .seg_out    (seg_b),
        .dp_out     (dp_b),
        .an_out     (an_b),
        .frame_done (fd_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reset u_a for one edge; afterwards the current cycle is cycle 0.
    task automatic pulse_reset_a();
        reset_a = 1'b1;
        step();
        reset_a = 1'b0;
    endtask

    // Check ncyc cycles of u_a starting at cycle 0 with a 6-cycle slot
    // (2 dark + 4 lit) and a 24-cycle frame.
    task automatic scan_check(input int ncyc, input logic [3:0] en, input string name);
        int         slot;
        int         pos;
        logic [3:0] ean;
        logic [6:0] eseg;
        logic       edp;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) step();
            slot = (c / 6) % 4;
            pos  = c % 6;
            if (pos < 2) begin
                ean  = 4'hF;
                eseg = 7'h7F;
                edp  = 1'b1;
            end else begin
                ean  = en[slot] ? 4'(~(4'b0001 << slot)) : 4'hF;
                eseg = pat[slot];
                edp  = dp_in[slot];
            end
            check($sformatf("%s_an_c%0d", name, c), an_a, ean);
            check($sformatf("%s_seg_c%0d", name, c), seg_a, eseg);
            check($sformatf("%s_dp_c%0d", name, c), dp_a, edp);
            check($sformatf("%s_fd_c%0d", name, c), fd_a, (c > 0 && c % 24 == 0) ? 1 : 0);
        end
    endtask

    initial begin
        logic prev_fd;
        int   slot;

        seg_in   = {pat[3], pat[2], pat[1], pat[0]};
        dp_in    = 4'b0101;
        digit_en = 4'b1111;
        reset_a  = 1'b1;
        reset_b  = 1'b1;
        step();

        // Reset state
        check("rst_an", an_a, 4'hF);
        check("rst_seg", seg_a, 7'h7F);
        check("rst_dp", dp_a, 1'b1);
        check("rst_fd", fd_a, 1'b0);
        reset_a = 1'b0;

        // Basic scan over two frames
        scan_check(50, 4'b1111, "basic");

        // Masking digit 2
        pulse_reset_a();
        digit_en = 4'b1011;
        scan_check(24, 4'b1011, "mask");

        // Stability of the lit digit against input changes
        digit_en = 4'b1111;
        pulse_reset_a();
        step(); step();                                   // cycle 2
        check("stab_c2", seg_a, 7'b1000000);
        step();                                           // cycle 3
        check("stab_c3", seg_a, 7'b1000000);
        seg_in[6:0] = 7'b0010000;
        step(); step();                                   // cycle 5
        check("stab_c5_seg", seg_a, 7'b1000000);
        check("stab_c5_an", an_a, 4'b1110);
        for (int i = 0; i < 21; i++) step();              // cycle 26
        check("stab_c26_seg", seg_a, 7'b0010000);
        check("stab_c26_an", an_a, 4'b1110);
        seg_in[6:0] = pat[0];

        // Reset during digit 2 dwell
        pulse_reset_a();
        for (int i = 0; i < 14; i++) step();              // cycle 14
        check("mid_pre_an", an_a, 4'b1011);
        check("mid_pre_seg", seg_a, 7'b0100100);
        reset_a = 1'b1;
        step();
        check("mid_rst_an", an_a, 4'hF);
        check("mid_rst_seg", seg_a, 7'h7F);
        check("mid_rst_fd", fd_a, 1'b0);
        reset_a = 1'b0;
        step(); step();                                   // cycle 2
        check("mid_post_an", an_a, 4'b1110);
        check("mid_post_seg", seg_a, 7'b1000000);

        // Zero blanking: after the single post-reset dark cycle, digits
        // step every 4 cycles with no gaps; frame_done at cycles 17 and 33.
        step();
        reset_b = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            step();
            slot = ((c - 1) / 4) % 4;
            check($sformatf("nob_an_c%0d", c), an_b, 4'(~(4'b0001 << slot)));
            check($sformatf("nob_seg_c%0d", c), seg_b, pat[slot]);
            check($sformatf("nob_fd_c%0d", c), fd_b, (c > 1 && (c - 1) % 16 == 0) ? 1 : 0);
        end

        // Random inputs: one-hot anodes, single-cycle frame_done
        pulse_reset_a();
        prev_fd = 1'b0;
        for (int i = 0; i < 24000; i++) begin
            seg_in   = 28'($urandom);
            dp_in    = 4'($urandom);
            digit_en = 4'($urandom);
            step();
            check("onehot_an", ($countones(~an_a) <= 1) ? 1 : 0, 1);
            check("fd_single", (fd_a && prev_fd) ? 1 : 0, 0);
            prev_fd = fd_a;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
